// File: rtl/wishbone_pkg.sv
// Shared types and helpers for the Wishbone classic arbiter.
package wishbone_pkg;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_GRANTED = 1'b1
   } arb_state_t;

   // Owner index width; a single controller still gets one bit.
   function automatic int owner_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first requester found scanning last+1, last+2, ... modulo NUM_CONTROLLERS.
module rr_priority_select
   import wishbone_pkg::*;
#(
   parameter int NUM_CONTROLLERS = 2,
   parameter int OWNER_W         = owner_w(NUM_CONTROLLERS)
) (
   input  logic [NUM_CONTROLLERS-1:0] i_req,
   input  logic [OWNER_W-1:0]         i_last,
   output logic                       o_found,
   output logic [OWNER_W-1:0]         o_idx
);

   int w_dist;
   int w_best;

   // Each requester is ranked by its distance from last+1; the smallest rank wins.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_dist  = 0;
      w_best  = NUM_CONTROLLERS;
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
         w_dist = (i + NUM_CONTROLLERS - 1 - int'(i_last)) % NUM_CONTROLLERS;
         if (i_req[i] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_found = 1'b1;
            o_idx   = OWNER_W'(i);
         end
      end
   end

endmodule

// File: rtl/wishbone_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic device between several controllers.
module wishbone_classic_arbiter
   import wishbone_pkg::*;
#(
   parameter int NUM_CONTROLLERS = 2,
   parameter int DAT_WIDTH       = 8
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NUM_CONTROLLERS-1:0]                ctl_cyc_i,
   input  logic [NUM_CONTROLLERS-1:0]                ctl_stb_i,
   input  logic [NUM_CONTROLLERS-1:0]                ctl_we_i,
   input  logic [NUM_CONTROLLERS-1:0][DAT_WIDTH-1:0] ctl_dat_i,
   output logic [NUM_CONTROLLERS-1:0]                ctl_ack_o,
   output logic [NUM_CONTROLLERS-1:0]                ctl_err_o,
   output logic [NUM_CONTROLLERS-1:0]                ctl_rty_o,
   output logic [DAT_WIDTH-1:0]                      ctl_dat_o,
   output logic                                      dev_cyc_o,
   output logic                                      dev_stb_o,
   output logic                                      dev_we_o,
   output logic [DAT_WIDTH-1:0]                      dev_dat_o,
   input  logic                                      dev_ack_i,
   input  logic                                      dev_err_i,
   input  logic                                      dev_rty_i,
   input  logic [DAT_WIDTH-1:0]                      dev_dat_i,
   output logic [NUM_CONTROLLERS-1:0]                gnt_o
);

   localparam int OWNER_W = owner_w(NUM_CONTROLLERS);

   arb_state_t                 r_state;
   arb_state_t                 w_state_nxt;
   logic [OWNER_W-1:0]         r_owner;
   logic [OWNER_W-1:0]         w_owner_nxt;
   logic [OWNER_W-1:0]         r_last;
   logic [OWNER_W-1:0]         w_last_nxt;
   logic                       w_found;
   logic [OWNER_W-1:0]         w_sel;
   logic                       w_granted;
   logic                       w_own_cyc;
   logic [NUM_CONTROLLERS-1:0] w_own_oh;

   rr_priority_select #(
      .NUM_CONTROLLERS (NUM_CONTROLLERS),
      .OWNER_W         (OWNER_W)
   ) u_sel (
      .i_req   (ctl_cyc_i),
      .i_last  (r_last),
      .o_found (w_found),
      .o_idx   (w_sel)
   );

   // last starts at the top index so controller 0 wins the first arbitration.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ARB_IDLE;
         r_owner <= '0;
         r_last  <= OWNER_W'(NUM_CONTROLLERS - 1);
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_own_oh  = '0;
      w_own_cyc = 1'b0;
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
         w_own_oh[i] = (r_owner == OWNER_W'(i));
      end
      w_own_cyc = |(ctl_cyc_i & w_own_oh);
      w_granted = (r_state == ARB_GRANTED);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      case (r_state)
         ARB_IDLE: begin
            if (w_found) begin
               w_owner_nxt = w_sel;
               w_state_nxt = ARB_GRANTED;
            end
         end
         ARB_GRANTED: begin
            if (!w_own_cyc) begin
               w_last_nxt  = r_owner;
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // Device side is a plain AND-OR mux of the owner, forced to zero outside a grant.
   always_comb begin
      dev_cyc_o = 1'b0;
      dev_stb_o = 1'b0;
      dev_we_o  = 1'b0;
      dev_dat_o = '0;
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
         if (w_granted && w_own_oh[i]) begin
            dev_cyc_o = ctl_cyc_i[i];
            dev_stb_o = ctl_stb_i[i];
            dev_we_o  = ctl_we_i[i];
            dev_dat_o = ctl_dat_i[i];
         end
      end
   end

   always_comb begin
      gnt_o     = '0;
      ctl_ack_o = '0;
      ctl_err_o = '0;
      ctl_rty_o = '0;
      if (w_granted) begin
         gnt_o     = w_own_oh;
         ctl_ack_o = w_own_oh & {NUM_CONTROLLERS{dev_ack_i}};
         ctl_err_o = w_own_oh & {NUM_CONTROLLERS{dev_err_i}};
         ctl_rty_o = w_own_oh & {NUM_CONTROLLERS{dev_rty_i}};
      end
   end

   assign ctl_dat_o = dev_dat_i;

`ifdef FORMAL
   a_gnt_onehot : assert property (@(posedge clk_i) $onehot0(gnt_o));
   a_cyc_owner  : assert property (@(posedge clk_i) dev_cyc_o |-> w_own_cyc);
   a_no_stray   : assert property (@(posedge clk_i)
                     ((ctl_ack_o | ctl_err_o | ctl_rty_o) & ~gnt_o) == '0);
`endif

endmodule

// File: doc/wishbone_classic_arbiter.md
# wishbone_classic_arbiter

Round-robin arbiter that shares one Wishbone B4 classic device between `NUM_CONTROLLERS` Wishbone classic controllers.
- Ownership is granted per bus cycle. A grant is held while the owner keeps `cyc` high, so multi-transfer locked cycles are supported.
- The block sits between the controller-side wishbone_classic instances and a single device (e.g. a register file or UART).

## Interface
Parameters:
- `NUM_CONTROLLERS`, default 2: number of requesting controllers; legal range 1..16.
- `DAT_WIDTH`, default 8: data width of both directions.

Ports:
- `clk_i`  in  1  sole clock; all state updates on its rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `ctl_cyc_i`  in  `NUM_CONTROLLERS`  per-controller `cyc`.
- `ctl_stb_i`  in  `NUM_CONTROLLERS`  per-controller `stb`.
- `ctl_we_i`  in  `NUM_CONTROLLERS`  per-controller `we`.
- `ctl_dat_i`  in  `NUM_CONTROLLERS` x `DAT_WIDTH`  per-controller write data.
- `ctl_ack_o`, `ctl_err_o`, `ctl_rty_o`  out  `NUM_CONTROLLERS` each  per-controller termination signals.
- `ctl_dat_o`  out  `DAT_WIDTH`  read data; broadcast to all controllers.
- `dev_cyc_o`, `dev_stb_o`, `dev_we_o`  out  1 each  device-side request.
- `dev_dat_o`  out  `DAT_WIDTH`  device-side write data.
- `dev_ack_i`, `dev_err_i`, `dev_rty_i`  in  1 each  device termination.
- `dev_dat_i`  in  `DAT_WIDTH`  device read data.
- `gnt_o`  out  `NUM_CONTROLLERS`  one-hot current owner; all zero when idle.

## Operation
- FSM has two states, `ARB_IDLE` and `ARB_GRANTED`. Registered state: `state`, `owner` (`OWNER_W = max(1, $clog2(NUM_CONTROLLERS))` bits) and `last`, the index of the previous owner.
- **ARB_IDLE**:
  - If any `ctl_cyc_i` bit is high, select the first requester scanning `last+1, last+2, …` modulo `NUM_CONTROLLERS`.
  - Register the selection into `owner`, go to `ARB_GRANTED`.
  - Otherwise stay.
- **ARB_GRANTED**:
  - `dev_cyc_o/stb_o/we_o/dat_o` are a combinational mux of the owner's inputs.
  - The owner's `ctl_ack_o/err_o/rty_o` bits are `dev_ack_i/err_i/rty_i`. All other bits are 0.
- **Release**: when `ctl_cyc_i[owner]` is low, `last <= owner` and the FSM goes to `ARB_IDLE`.
  - `dev_cyc_o` follows the owner's `cyc` combinationally, so it falls in the same cycle the owner drops it.
- **Outside `ARB_GRANTED`**: all `dev_*_o` are 0, all `ctl_ack/err/rty_o` are 0, and `gnt_o` is 0.
- `ctl_dat_o` = `dev_dat_i` at all times.
- **Requester behaviour**: non-owners that assert `cyc` are stalled with no termination until granted. They are never dropped.
- **Device misbehaviour**: a device termination while in `ARB_IDLE` is ignored and not forwarded.
- **NUM_CONTROLLERS = 1**: the same FSM applies; round-robin degenerates to always selecting 0.

## Timing
- **Reset values** (`rst_ni` low, asynchronous): `state = ARB_IDLE`, `owner = 0`, `last = NUM_CONTROLLERS-1`.
  - Controller 0 therefore wins the first arbitration.
  - All outputs are 0.
- **Reset mid-cycle**: the grant is dropped immediately and `dev_cyc_o` goes to 0 asynchronously.
- **Grant latency**: a controller raising `cyc` at edge N, with the arbiter idle, sees `gnt_o` and `dev_cyc_o` high after edge N+1.
  - An asynchronous-ack device completes the first transfer in that same cycle.
- **Handover**: owner drops `cyc` in cycle K → `ARB_IDLE` in cycle K+1 (arbitration cycle) → new owner driven in K+2.
  - There is exactly one dead cycle between owners.
- **Simultaneous requests**: strictly round-robin from `last+1`. No controller waits more than `NUM_CONTROLLERS-1` grants.
- **Locked cycles**: back-to-back `stb` transfers with `cyc` held remain with the owner indefinitely. There is no timeout.

## Structure
- **Shared package `wishbone_pkg`**:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_GRANTED`}.
  - A function computing `OWNER_W`.
- **Sub-module `rr_priority_select`**: combinational; takes a request vector and `last`; returns `found` and an index. Parameterised on `NUM_CONTROLLERS`.
- **Top level**: holds the FSM, registers and muxes.
- **Formal**: properties go under `ifdef FORMAL`:
  - `gnt_o` is one-hot or zero.
  - `dev_cyc_o` implies `ctl_cyc_i[owner]`.
  - No termination is forwarded to a non-owner.

## Test plan
- **Reset**: hold `rst_ni` low for 3 cycles with `ctl_cyc_i = 2'b11` → all outputs 0. After release, `gnt_o = 2'b01` one cycle later.
- **Single write**: controller 1 writes `8'hA5` to a sync-ack device (2 wait states).
  - `gnt_o = 2'b10` and `dev_dat_o = 8'hA5`.
  - `ctl_ack_o = 2'b10` for exactly one cycle.
  - After controller 1 drops `cyc`, `gnt_o` returns to 0 on the next cycle.
- **Contention**: controllers 0 and 1 request continuously, each dropping `cyc` after one ack → grants alternate 0,1,0,1 with one idle cycle between each.
- **Locked cycle**: controller 0 holds `cyc` across 4 acked transfers while controller 1 requests.
  - Controller 1 gets no `ack` and no grant until controller 0 drops `cyc`.
  - Controller 1 is then granted 2 cycles later.
- **Async reset mid-transfer**: pulse `rst_ni` low between clock edges while `dev_cyc_o = 1` → `dev_cyc_o` falls without a clock edge. Next grant goes to controller 0.
- **Spurious device ack**: `dev_ack_i = 1` while idle → `ctl_ack_o` remains 0 and state remains `ARB_IDLE`.
